// File: rtl/logic_gate_unit.sv
// Registered NUM_IN-operand bitwise gate with a selectable operation, valid/ready handshake and accept counter.
// Optional feature: define LOGIC_GATE_UNIT_PARITY_EN to add the registered out_parity output.
module logic_gate_unit #(
  parameter int WIDTH  = 8,
  parameter int NUM_IN = 2,
  parameter int CNT_W  = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [NUM_IN*WIDTH-1:0]   in_data,
  input  logic [2:0]                in_op,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          out_data,
`ifdef LOGIC_GATE_UNIT_PARITY_EN
  output logic                      out_parity,
`endif
  output logic [CNT_W-1:0]          out_count
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] w_and;
  logic [WIDTH-1:0] w_or;
  logic [WIDTH-1:0] w_xor;
  logic [WIDTH-1:0] w_op0;
  logic [WIDTH-1:0] w_result;
  logic             w_accept;

  logic             r_valid;
  logic [WIDTH-1:0] r_data;
  logic [CNT_W-1:0] r_count;

  // Gather bit gi of every operand into one column, then reduce the column.
  genvar gi, gk;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      logic [NUM_IN-1:0] w_col;
      for (gk = 0; gk < NUM_IN; gk++) begin : g_opnd
        assign w_col[gk] = in_data[gk*WIDTH + gi];
      end
      assign w_and[gi] = &w_col;
      assign w_or[gi]  = |w_col;
      assign w_xor[gi] = ^w_col;
    end
  endgenerate

  assign w_op0 = in_data[WIDTH-1:0];

  always_comb begin
    w_result = '0;
    case (in_op)
      3'd0:    w_result = w_and;
      3'd1:    w_result = w_or;
      3'd2:    w_result = ~w_and;
      3'd3:    w_result = ~w_or;
      3'd4:    w_result = w_xor;
      3'd5:    w_result = ~w_xor;
      3'd6:    w_result = ~w_op0;
      default: w_result = w_op0;
    endcase
  end

  // A full output register can still accept when the downstream drains it this cycle.
  assign in_ready = !r_valid || out_ready;
  assign w_accept = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_count <= '0;
    end else if (w_accept) begin
      r_valid <= 1'b1;
      r_data  <= w_result;
      r_count <= r_count + CNT_ONE;
    end else if (out_ready) begin
      r_valid <= 1'b0;
    end
  end

`ifdef LOGIC_GATE_UNIT_PARITY_EN
  logic r_parity;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_parity <= 1'b0;
    end else if (w_accept) begin
      r_parity <= ^w_result;
    end
  end

  assign out_parity = r_parity;
`endif

  assign out_valid = r_valid;
  assign out_data  = r_data;
  assign out_count = r_count;

endmodule
